audio_adc_rx: RTL and testbench

AUDIO_ADC_RX -- requirements
Module: audio_adc_rx

---
 rtl/audio_adc_rx.sv | 172 +++++++++++++++++
 tb/tb_audio_adc_rx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_rx.sv
// ============================================================================
// audio_adc_rx -- I2S master receiver for a 24-bit stereo audio ADC codec.
//
// The block generates the codec bit clock (bclk) and the left/right clock
// (adclrck) from sys_clk. It captures one 24-bit left word and one 24-bit
// right word per 64-slot frame, and presents them as a stereo pair with a
// valid/ack handshake.
//
// Optional feature: define AUDIO_ADC_RX_PEAK_EN to add the 'peak' output,
// which holds the largest sample magnitude seen since the last ack or reset.
//
// Parameters
//   BCLK_HALF  sys_clk cycles per bclk half-period (2..255)
//
// Ports
//   sys_clk     in   system clock
//   rst         in   synchronous active-low reset
//   bclk        out  codec bit clock (this block is the master)
//   adclrck     out  left/right clock, 0 = left, 1 = right
//   adcdat      in   serial ADC data, sampled when bclk rises
//   data_left   out  last captured left sample (two's complement)
//   data_right  out  last captured right sample (two's complement)
//   valid       out  a new stereo pair is held on data_left/data_right
//   ack         in   one-cycle pulse: consumer has taken the pair
//   overrun     out  sticky: a pair was overwritten before it was acked
//   peak        out  (AUDIO_ADC_RX_PEAK_EN only) max |sample| since ack/reset
// ============================================================================
module audio_adc_rx #(
    parameter int BCLK_HALF = 8
) (
    input  logic        sys_clk,
    input  logic        rst,
    output logic        bclk,
    output logic        adclrck,
    input  logic        adcdat,
    output logic [23:0] data_left,
    output logic [23:0] data_right,
    output logic        valid,
    input  logic        ack,
    output logic        overrun
`ifdef AUDIO_ADC_RX_PEAK_EN
    ,
    output logic [23:0] peak
`endif
);

    localparam logic [7:0] HALF = 8'(BCLK_HALF);

    logic [7:0]  div_cnt;
    logic        div_tick;
    logic        bclk_rise;
    logic        bclk_fall;
    logic [5:0]  slot;
    logic [5:0]  slot_next;
    logic        in_left;
    logic        in_right;
    logic [23:0] shift_l;
    logic [23:0] shift_r;
    logic        pair_done;
    logic        ack_take;

    // The divider runs 1..HALF in steady state. Reset parks it at 0, so
    // the first toggle lands exactly HALF cycles after reset is released.
    assign div_tick  = (div_cnt == HALF);
    assign bclk_rise = div_tick && !bclk;
    assign bclk_fall = div_tick && bclk;
    assign slot_next = slot + 6'd1;

    // I2S: slot 0 of each channel is the one-bclk delay; 24 data bits follow.
    assign in_left  = (slot >= 6'd1)  && (slot <= 6'd24);
    assign in_right = (slot >= 6'd33) && (slot <= 6'd56);

    // Handshake: valid rises when a pair is loaded and stays high until ack
    // is sampled high while valid=1 (ack with valid=0 is ignored). A new pair
    // arriving while valid=1 and no ack overwrites the data and sets overrun;
    // a pair arriving in the ack cycle is simply the next pair, so valid
    // stays high and overrun is left as it was.
    assign ack_take = ack && valid;

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            div_cnt    <= 8'd0;
            bclk       <= 1'b0;
            slot       <= 6'd0;
            adclrck    <= 1'b0;
            shift_l    <= 24'd0;
            shift_r    <= 24'd0;
            pair_done  <= 1'b0;
            data_left  <= 24'd0;
            data_right <= 24'd0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (div_tick) begin
                div_cnt <= 8'd1;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            // Slot and adclrck move only on bclk falling edges.
            if (bclk_fall) begin
                slot    <= slot_next;
                adclrck <= slot_next[5];
            end

            if (bclk_rise && in_left) begin
                shift_l <= {shift_l[22:0], adcdat};
            end
            if (bclk_rise && in_right) begin
                shift_r <= {shift_r[22:0], adcdat};
            end

            // The right LSB lands in the slot-56 rise cycle; the pair is
            // published one cycle later from the settled shift registers.
            pair_done <= bclk_rise && (slot == 6'd56);

            if (pair_done) begin
                data_left  <= shift_l;
                data_right <= shift_r;
                valid      <= 1'b1;
                if (valid && !ack_take) begin
                    overrun <= 1'b1;
                end
            end else if (ack_take) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

`ifdef AUDIO_ADC_RX_PEAK_EN
    // Magnitude of a two's complement sample; -8388608 has no positive
    // 24-bit counterpart and saturates to the largest positive value.
    function automatic logic [23:0] mag24(input logic [23:0] x);
        logic [23:0] m;
        if (x == 24'h800000) begin
            m = 24'h7FFFFF;
        end else if (x[23]) begin
            m = (~x) + 24'd1;
        end else begin
            m = x;
        end
        return m;
    endfunction

    logic [23:0] mag_l;
    logic [23:0] mag_r;
    logic [23:0] pair_mag;

    always_comb begin
        mag_l    = mag24(shift_l);
        mag_r    = mag24(shift_r);
        pair_mag = (mag_l > mag_r) ? mag_l : mag_r;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            peak <= 24'd0;
        end else if (pair_done) begin
            if (ack_take) begin
                peak <= pair_mag;
            end else if (pair_mag > peak) begin
                peak <= pair_mag;
            end
        end else if (ack_take) begin
            peak <= 24'd0;
        end
    end
`endif

endmodule

// File: tb/tb_audio_adc_rx.sv
// ============================================================================
// tb_audio_adc_rx -- directed self-checking bench for audio_adc_rx.
//
// A small I2S codec model follows the bclk falling edges, keeps its own slot
// count and drives adcdat from the words word_l/word_r. The main initial
// block walks through reset, clock timing, capture, overrun, ack-in-
// completion-cycle and mid-frame reset, checking hand-computed values.
// Build with +define+AUDIO_ADC_RX_PEAK_EN to also check the peak output.
// ============================================================================
`timescale 1ns/1ps
module tb_audio_adc_rx;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  logic        bclk;
  logic        adclrck;
  logic        adcdat;
  logic [23:0] data_left;
  logic [23:0] data_right;
  logic        valid;
  logic        ack;
  logic        overrun;
`ifdef AUDIO_ADC_RX_PEAK_EN
  logic [23:0] peak;
`endif

  audio_adc_rx #(.BCLK_HALF(8)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .bclk       (bclk),
    .adclrck    (adclrck),
    .adcdat     (adcdat),
    .data_left  (data_left),
    .data_right (data_right),
    .valid      (valid),
    .ack        (ack),
    .overrun    (overrun)
`ifdef AUDIO_ADC_RX_PEAK_EN
    ,
    .peak       (peak)
`endif
  );

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- codec model and timing monitor ----------------
  logic [23:0] word_l = 24'd0;
  logic [23:0] word_r = 24'd0;

  int   cyc = 0;
  int   tb_slot = 0;
  logic prev_bclk = 1'b0;
  logic prev_lr = 1'b0;
  logic prev_valid = 1'b0;
  logic fell;
  int   t_bclk_rise = 0;
  int   t_bclk_rise_prev = 0;
  int   t_lr_rise = 0;
  int   t_lr_rise_prev = 0;
  int   t_lr_fall = 0;
  int   t_56 = 0;
  int   t_valid = 0;
  int   n56 = 0;
  int   lr_misalign = 0;
  int   lr_wrong = 0;

  // Slots outside the data windows carry 1s so a capture off by a slot
  // picks up wrong bits.
  function automatic logic codec_bit(input int s);
    logic b;
    b = 1'b1;
    if (s >= 1 && s <= 24) b = word_l[24 - s];
    else if (s >= 33 && s <= 56) b = word_r[56 - s];
    return b;
  endfunction

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(posedge sys_clk) begin
    #1;
    fell = 1'b0;
    if (!rst) begin
      tb_slot    = 0;
      prev_bclk  = 1'b0;
      prev_lr    = 1'b0;
      prev_valid = 1'b0;
      adcdat     = codec_bit(0);
    end else begin
      if (prev_bclk && !bclk) begin
        tb_slot = (tb_slot + 1) % 64;
        adcdat  = codec_bit(tb_slot);
        fell    = 1'b1;
      end
      if (!prev_bclk && bclk) begin
        t_bclk_rise_prev = t_bclk_rise;
        t_bclk_rise      = cyc;
        if (tb_slot == 56) begin
          n56++;
          t_56 = cyc;
        end
      end
      if (adclrck !== prev_lr) begin
        if (!fell) lr_misalign++;
        if (adclrck) begin
          t_lr_rise_prev = t_lr_rise;
          t_lr_rise      = cyc;
        end else begin
          t_lr_fall = cyc;
        end
      end
      if (adclrck !== (tb_slot >= 32)) lr_wrong++;
      if (valid && !prev_valid) t_valid = cyc;
      prev_bclk  = bclk;
      prev_lr    = adclrck;
      prev_valid = valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_n56(input int target);
    int k;
    k = 0;
    while (n56 < target && k < 3000) begin
      @(negedge sys_clk);
      k++;
    end
    chk("wait_slot56", 32'(n56 >= target), 32'd1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge sys_clk);
    ack = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bclk"},    32'(bclk),       32'd0);
    chk({tag, "_adclrck"}, 32'(adclrck),    32'd0);
    chk({tag, "_left"},    32'(data_left),  32'd0);
    chk({tag, "_right"},   32'(data_right), 32'd0);
    chk({tag, "_valid"},   32'(valid),      32'd0);
    chk({tag, "_overrun"}, 32'(overrun),    32'd0);
`ifdef AUDIO_ADC_RX_PEAK_EN
    chk({tag, "_peak"},    32'(peak),       32'd0);
`endif
  endtask

  // First bclk rise is seen BCLK_HALF+1 counted edges after the negedge on
  // which rst goes high (one edge samples rst=1, then 8 more).
  task automatic release_reset();
    int t_rel;
    int k;
    rst   = 1'b1;
    t_rel = cyc;
    k = 0;
    while (bclk !== 1'b1 && k < 100) begin
      @(negedge sys_clk);
      k++;
    end
    chk("first_rise", 32'(t_bclk_rise - t_rel), 32'd9);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t_rel;
    int k;
    rst    = 1'b0;
    ack    = 1'b0;
    adcdat = 1'b0;
    word_l = 24'h123456;
    word_r = 24'hA5A5A5;
    repeat (4) @(negedge sys_clk);
    check_zero("reset");

    // Frame 0: first pair, latency and bclk period.
    release_reset();
    wait_n56(1);
    @(negedge sys_clk);
    chk("p1_left",    32'(data_left),  32'h123456);
    chk("p1_right",   32'(data_right), 32'hA5A5A5);
    chk("p1_valid",   32'(valid),      32'd1);
    chk("p1_overrun", 32'(overrun),    32'd0);
    chk("p1_latency", 32'(t_valid - t_56), 32'd1);
    chk("bclk_period", 32'(t_bclk_rise - t_bclk_rise_prev), 32'd16);
`ifdef AUDIO_ADC_RX_PEAK_EN
    chk("p1_peak",    32'(peak),       32'h5A5A5B);
`endif

    // Frame 1: no ack -> overwrite and overrun.
    word_l = 24'h00FF00;
    word_r = 24'hFFFFFE;
    wait_n56(2);
    @(negedge sys_clk);
    chk("p2_left",    32'(data_left),  32'h00FF00);
    chk("p2_right",   32'(data_right), 32'hFFFFFE);
    chk("p2_valid",   32'(valid),      32'd1);
    chk("p2_overrun", 32'(overrun),    32'd1);
    chk("lr_period",  32'(t_lr_rise - t_lr_rise_prev), 32'd1024);
    chk("lr_low",     32'(t_lr_rise - t_lr_fall), 32'd512);
`ifdef AUDIO_ADC_RX_PEAK_EN
    chk("p2_peak",    32'(peak),       32'h5A5A5B);
`endif

    pulse_ack();
    chk("ack_valid",   32'(valid),     32'd0);
    chk("ack_overrun", 32'(overrun),   32'd0);
    chk("ack_hold",    32'(data_left), 32'h00FF00);
`ifdef AUDIO_ADC_RX_PEAK_EN
    chk("ack_peak",    32'(peak),      32'd0);
`endif
    pulse_ack();
    chk("idle_ack_valid",   32'(valid),   32'd0);
    chk("idle_ack_overrun", 32'(overrun), 32'd0);

    // Frame 2: fresh pair with valid low beforehand.
    word_l = 24'h654321;
    word_r = 24'h0ABCDE;
    wait_n56(3);
    @(negedge sys_clk);
    chk("p3_left",    32'(data_left),  32'h654321);
    chk("p3_right",   32'(data_right), 32'h0ABCDE);
    chk("p3_valid",   32'(valid),      32'd1);
    chk("p3_overrun", 32'(overrun),    32'd0);
`ifdef AUDIO_ADC_RX_PEAK_EN
    chk("p3_peak",    32'(peak),       32'h654321);
`endif

    // Frame 3: ack lands exactly in the completion cycle.
    word_l = 24'h800000;
    word_r = 24'h000010;
    wait_n56(4);
    pulse_ack();
    chk("p4_left",    32'(data_left),  32'h800000);
    chk("p4_right",   32'(data_right), 32'h000010);
    chk("p4_valid",   32'(valid),      32'd1);
    chk("p4_overrun", 32'(overrun),    32'd0);
`ifdef AUDIO_ADC_RX_PEAK_EN
    chk("p4_peak",    32'(peak),       32'h7FFFFF);
`endif
    pulse_ack();
    chk("p4_ack_valid", 32'(valid), 32'd0);
`ifdef AUDIO_ADC_RX_PEAK_EN
    chk("p4_ack_peak",  32'(peak),  32'd0);
`endif

    // Frame 4: leave a pair pending, then reset at slot 40 of frame 5.
    word_l = 24'h111111;
    word_r = 24'h222222;
    wait_n56(5);
    @(negedge sys_clk);
    chk("pj_valid", 32'(valid), 32'd1);
    k = 0;
    while (tb_slot != 40 && k < 2000) begin
      @(negedge sys_clk);
      k++;
    end
    chk("reach_slot40", 32'(tb_slot), 32'd40);
    rst = 1'b0;
    @(negedge sys_clk);
    check_zero("midreset");
    word_l = 24'h0F0F0F;
    word_r = 24'hF0F0F0;
    t_rel = cyc;
    release_reset();
    wait_n56(6);
    chk("p5_pre_valid", 32'(valid), 32'd0);
    chk("p5_frame_time", 32'(t_56 - t_rel), 32'd905);
    @(negedge sys_clk);
    chk("p5_left",    32'(data_left),  32'h0F0F0F);
    chk("p5_right",   32'(data_right), 32'hF0F0F0);
    chk("p5_valid",   32'(valid),      32'd1);
    chk("p5_overrun", 32'(overrun),    32'd0);
    chk("p5_latency", 32'(t_valid - t_56), 32'd1);

    chk("lr_edge_align", 32'(lr_misalign), 32'd0);
    chk("lr_level",      32'(lr_wrong),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
